// File: rtl/checker_read_if.sv
// checker_read handshake bundle: mode_* toward the checker control interface,
// rd_*/cpl_* toward the PCIe requester logic.
interface checker_read_if;
    logic [1:0]  mode_mode;
    logic        mode_start;
    logic [63:0] mode_addr;
    logic        mode_end;
    logic        mode_error;
    logic [63:0] mode_data;
    logic        rd_req;
    logic [63:0] rd_addr;
    logic        rd_ack;
    logic        cpl_valid;
    logic [63:0] cpl_data;
    logic        cpl_err;

    // Checker side: consumes the run request, issues the read.
    modport slave (
        input  mode_mode, mode_start, mode_addr, rd_ack, cpl_valid, cpl_data, cpl_err,
        output mode_end, mode_error, mode_data, rd_req, rd_addr
    );

    // Control / requester side.
    modport master (
        output mode_mode, mode_start, mode_addr, rd_ack, cpl_valid, cpl_data, cpl_err,
        input  mode_end, mode_error, mode_data, rd_req, rd_addr
    );
endinterface

// File: rtl/checker_read.sv
// checker_read: executes CHECKER_MODE_READ, fetching one 64-bit quad word of host
// memory and returning it (or an error) through the mode_* handshake.
// Optional feature macro: CHECKER_READ_TIMEOUT_EN (completion timeout counter).
`ifndef CHECKER_MODE_READ
`define CHECKER_MODE_READ 2'd2
`endif

module checker_read #(
    parameter logic [15:0] timeout = 16'd50000
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    checker_read_if.slave  bus,
    output logic           busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t r_state;
    logic   w_go;
    logic   w_timeout;

    assign w_go = bus.mode_start && (bus.mode_mode == `CHECKER_MODE_READ);

`ifdef CHECKER_READ_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic [16:0] w_cnt_inc;
    logic        w_counting;

    assign w_counting = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    assign w_cnt_inc  = {1'b0, r_cnt} + 17'd1;
    // Fires on the cycle whose increment would reach the limit, so an
    // acceptance at cycle A reports the timeout at A+timeout+1.
    assign w_timeout  = w_counting && (w_cnt_inc == {1'b0, timeout});

    // Saturating completion timer, running only while a completion is owed.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= 16'd0;
        end else if (w_counting) begin
            r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : w_cnt_inc[15:0];
        end else begin
            r_cnt <= 16'd0;
        end
    end
`else
    logic [15:0] w_unused_timeout;

    assign w_unused_timeout = timeout;
    assign w_timeout        = 1'b0;
`endif

    // Read sequencer: state, request port and result pulses, all registered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= ST_IDLE;
            bus.mode_end   <= 1'b0;
            bus.mode_error <= 1'b0;
            bus.mode_data  <= 64'd0;
            bus.rd_req     <= 1'b0;
            bus.rd_addr    <= 64'd0;
            busy           <= 1'b0;
        end else begin
            bus.mode_end   <= 1'b0;
            bus.mode_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        busy <= 1'b1;
                        if (bus.mode_addr[2:0] != 3'd0) begin
                            bus.mode_error <= 1'b1;
                            r_state        <= ST_DONE;
                        end else begin
                            bus.rd_req  <= 1'b1;
                            bus.rd_addr <= bus.mode_addr;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Acceptance beats a same-cycle abort; the abort is then
                    // handled from WAIT through DRAIN.
                    if (bus.rd_ack) begin
                        bus.rd_req <= 1'b0;
                        r_state    <= ST_WAIT;
                    end else if (!w_go) begin
                        bus.rd_req <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.cpl_valid) begin
                        if (bus.cpl_err) begin
                            bus.mode_error <= 1'b1;
                        end else begin
                            bus.mode_end  <= 1'b1;
                            bus.mode_data <= bus.cpl_data;
                        end
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        bus.mode_error <= 1'b1;
                        r_state        <= ST_DONE;
                    end else if (!w_go) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The orphaned completion is swallowed so it cannot be
                    // mistaken for the answer to a later request.
                    if (bus.cpl_valid || w_timeout) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (!bus.mode_start) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    bus.rd_req <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checker_read.sv
// Directed self-checking bench for checker_read.
`ifndef CHECKER_MODE_READ
`define CHECKER_MODE_READ 2'd2
`endif

module tb_checker_read;

    localparam logic [1:0]  MODE_READ   = `CHECKER_MODE_READ;
    localparam logic [1:0]  MODE_SINGLE = 2'(MODE_READ + 2'd1);
    localparam logic [15:0] TMO         = 16'd16;
    localparam logic [63:0] DATA_A      = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] DATA_B      = 64'h01234567_89ABCDEF;

    logic sys_clk;
    logic sys_rst;
    logic busy;
    int   n_tests;
    int   n_fail;

    checker_read_if bus ();

    checker_read #(.timeout(TMO)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus),
        .busy    (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sys_rst = 1'b1;
        bus.mode_mode  = 2'd0;
        bus.mode_start = 1'b0;
        bus.mode_addr  = 64'd0;
        bus.rd_ack     = 1'b0;
        bus.cpl_valid  = 1'b0;
        bus.cpl_data   = 64'd0;
        bus.cpl_err    = 1'b0;
        ticks(2);
        chk("rst_rd_req", 64'(bus.rd_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mode_data", bus.mode_data, 64'd0);
        chk("rst_end_err", 64'({bus.mode_end, bus.mode_error}), 64'd0);
        sys_rst = 1'b0;
        tick();

        // Normal read: T = now.
        bus.mode_mode  = MODE_READ;
        bus.mode_addr  = 64'h1000;
        bus.mode_start = 1'b1;
        tick();                                   // T+1
        chk("rd_req_T1", 64'(bus.rd_req), 64'd1);
        chk("rd_addr_T1", bus.rd_addr, 64'h1000);
        chk("busy_T1", 64'(busy), 64'd1);
        bus.rd_ack = 1'b1;
        tick();                                   // T+2
        bus.rd_ack = 1'b0;
        chk("rd_req_drop", 64'(bus.rd_req), 64'd0);
        tick();                                   // T+3
        tick();                                   // T+4
        bus.cpl_valid = 1'b1;
        bus.cpl_data  = DATA_A;
        tick();                                   // T+5
        bus.cpl_valid = 1'b0;
        chk("end_T5", 64'(bus.mode_end), 64'd1);
        chk("err_T5", 64'(bus.mode_error), 64'd0);
        chk("data_T5", bus.mode_data, DATA_A);
        tick();                                   // T+6
        chk("end_T6", 64'(bus.mode_end), 64'd0);
        chk("busy_done", 64'(busy), 64'd1);
        bus.mode_start = 1'b0;
        tick();                                   // T+7
        chk("idle_T7", 64'(busy), 64'd0);

        // Misaligned address.
        bus.mode_addr  = 64'h1004;
        bus.mode_start = 1'b1;
        tick();
        chk("mis_err", 64'(bus.mode_error), 64'd1);
        chk("mis_no_req", 64'(bus.rd_req), 64'd0);
        tick();
        chk("mis_err_1cyc", 64'(bus.mode_error), 64'd0);
        chk("mis_no_req2", 64'(bus.rd_req), 64'd0);
        bus.mode_start = 1'b0;
        tick();
        chk("mis_idle", 64'(busy), 64'd0);

        // Completion error keeps old data.
        bus.mode_addr  = 64'h2000;
        bus.mode_start = 1'b1;
        tick();
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack    = 1'b0;
        bus.cpl_valid = 1'b1;
        bus.cpl_err   = 1'b1;
        bus.cpl_data  = 64'h1111_1111_1111_1111;
        tick();
        bus.cpl_valid = 1'b0;
        bus.cpl_err   = 1'b0;
        chk("cerr_err", 64'(bus.mode_error), 64'd1);
        chk("cerr_end", 64'(bus.mode_end), 64'd0);
        chk("cerr_data", bus.mode_data, DATA_A);
        bus.mode_start = 1'b0;
        ticks(2);
        chk("cerr_idle", 64'(busy), 64'd0);

        // Timeout: acceptance at A.
        bus.mode_addr  = 64'h3000;
        bus.mode_start = 1'b1;
        tick();
        bus.rd_ack = 1'b1;                        // A
        tick();                                   // A+1
        bus.rd_ack = 1'b0;
        ticks(15);                                // A+16
        chk("tmo_quiet_A16", 64'(bus.mode_error), 64'd0);
        tick();                                   // A+17
`ifdef CHECKER_READ_TIMEOUT_EN
        chk("tmo_err_A17", 64'(bus.mode_error), 64'd1);
        ticks(13);                                // A+30
        bus.cpl_valid = 1'b1;
        bus.cpl_data  = 64'h5555_5555_5555_5555;
        tick();
        bus.cpl_valid = 1'b0;
        chk("tmo_stray_end", 64'(bus.mode_end), 64'd0);
        chk("tmo_stray_data", bus.mode_data, DATA_A);
`else
        chk("notmo_busy", 64'(busy), 64'd1);
        bus.cpl_valid = 1'b1;
        bus.cpl_err   = 1'b1;
        tick();
        bus.cpl_valid = 1'b0;
        bus.cpl_err   = 1'b0;
        chk("notmo_cerr", 64'(bus.mode_error), 64'd1);
        chk("notmo_data", bus.mode_data, DATA_A);
`endif
        bus.mode_start = 1'b0;
        ticks(2);
        chk("tmo_idle", 64'(busy), 64'd0);

        // Abort after acceptance, then restart while the stale completion is owed.
        bus.mode_addr  = 64'h4000;
        bus.mode_start = 1'b1;
        tick();
        bus.rd_ack = 1'b1;                        // A
        tick();                                   // A+1
        bus.rd_ack = 1'b0;
        tick();                                   // A+2
        bus.mode_start = 1'b0;
        tick();                                   // A+3 -> DRAIN
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_pulses", 64'({bus.mode_end, bus.mode_error}), 64'd0);
        bus.mode_addr  = 64'h5000;
        bus.mode_start = 1'b1;
        ticks(2);
        chk("drain_no_req", 64'(bus.rd_req), 64'd0);
        bus.cpl_valid = 1'b1;
        bus.cpl_data  = 64'hBADBAD00_BADBAD00;
        tick();
        bus.cpl_valid = 1'b0;
        chk("stale_pulses", 64'({bus.mode_end, bus.mode_error}), 64'd0);
        chk("stale_data", bus.mode_data, DATA_A);
        chk("stale_no_req", 64'(bus.rd_req), 64'd0);
        tick();
        chk("restart_req", 64'(bus.rd_req), 64'd1);
        chk("restart_addr", bus.rd_addr, 64'h5000);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack    = 1'b0;
        bus.cpl_valid = 1'b1;
        bus.cpl_data  = DATA_B;
        tick();
        bus.cpl_valid = 1'b0;
        chk("restart_end", 64'(bus.mode_end), 64'd1);
        chk("restart_data", bus.mode_data, DATA_B);
        bus.mode_start = 1'b0;
        ticks(2);

        // Other mode is ignored.
        bus.mode_mode  = MODE_SINGLE;
        bus.mode_addr  = 64'h6000;
        bus.mode_start = 1'b1;
        ticks(2);
        chk("single_busy", 64'(busy), 64'd0);
        chk("single_no_req", 64'(bus.rd_req), 64'd0);

        // Reset during WAIT.
        bus.mode_mode = MODE_READ;
        tick();
        chk("pre_rst_req", 64'(bus.rd_req), 64'd1);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        #1;
        sys_rst = 1'b1;
        #1;
        chk("arst_req", 64'(bus.rd_req), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_data", bus.mode_data, 64'd0);
        chk("arst_addr", bus.rd_addr, 64'd0);
        bus.mode_start = 1'b0;
        #1;
        sys_rst = 1'b0;
        tick();
        bus.cpl_valid = 1'b1;
        bus.cpl_data  = DATA_A;
        tick();
        bus.cpl_valid = 1'b0;
        chk("post_rst_end", 64'(bus.mode_end), 64'd0);
        chk("post_rst_data", bus.mode_data, 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
